serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 97 +++++++++
 tb/tb_serial_subtractor.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B, one bit per clock, LSB first,
// through a single full-subtractor cell with a registered borrow.
//
// state  | meaning
// IDLE   | waiting for START; result registers hold the last completed operation
// RUN    | one difference bit per cycle, WIDTH cycles
// DONE   | one-cycle completion pulse; a held START restarts from here
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BOUT,
  output logic             ZERO
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             diff_bit;
  logic             borrow_next;
  logic [WIDTH-1:0] sr_next;
  logic             last_bit;
  logic             accept;

  always_comb begin
    diff_bit    = sa[0] ^ sb[0] ^ borrow;
    borrow_next = (~sa[0] & sb[0]) | (~sa[0] & borrow) | (sb[0] & borrow);
    sr_next     = {diff_bit, sr[WIDTH-1:1]};
    last_bit    = (cnt == CW'(WIDTH - 1));
    // Accepting in DONE as well as IDLE gives back-to-back operations every WIDTH+1 edges
    accept      = START && ((state == S_IDLE) || (state == S_DONE));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      D      <= '0;
      BOUT   <= 1'b0;
      ZERO   <= 1'b1;
    end else begin
      case (state)
        S_RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          sr     <= sr_next;
          borrow <= borrow_next;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            D     <= sr_next;
            BOUT  <= borrow_next;
            ZERO  <= (sr_next == '0);
            state <= S_DONE;
          end
        end
        S_IDLE, S_DONE: begin
          if (accept) begin
            sa     <= A;
            sb     <= B;
            sr     <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            state  <= S_RUN;
          end else begin
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY = (state == S_RUN) || (state == S_DONE);
  assign DONE = (state == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, reset abort,
// and a back-to-back random regression against an arithmetic reference.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] D;
  logic         BOUT;
  logic         ZERO;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] prev_d;
  logic         prev_bout;
  logic         prev_zero;

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .D(D), .BOUT(BOUT), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular subtraction and unsigned compare.
  function automatic logic [W-1:0] ref_d(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned r;
    r = (int'(a) - int'(b) + (1 << W)) % (1 << W);
    return W'(r);
  endfunction

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    chk({tag, "_done"}, DONE, 1'b1);
    chk({tag, "_d"},    D,    ref_d(a, b));
    chk({tag, "_bout"}, BOUT, (a < b));
    chk({tag, "_zero"}, ZERO, (ref_d(a, b) == '0));
    prev_d    = ref_d(a, b);
    prev_bout = (a < b);
    prev_zero = (ref_d(a, b) == '0);
  endtask

  // Single operation with START pulsed for one cycle; optionally pulses START mid-run.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit poke);
    A = a; B = b; START = 1'b1;
    tick();
    START = 1'b0;
    A = 'x; B = 'x;
    chk({tag, "_busy0"}, BUSY, 1'b1);
    chk({tag, "_done0"}, DONE, 1'b0);
    for (int n = 1; n <= W; n++) begin
      if (poke && n == 3) begin
        A = 8'h10; B = 8'h01; START = 1'b1;
      end else begin
        START = 1'b0;
      end
      tick();
      if (n < W) begin
        chk({tag, "_busy_run"}, BUSY, 1'b1);
        chk({tag, "_done_run"}, DONE, 1'b0);
        chk({tag, "_d_hold"},   D,    prev_d);
        chk({tag, "_b_hold"},   BOUT, prev_bout);
        chk({tag, "_z_hold"},   ZERO, prev_zero);
      end else begin
        chk({tag, "_busy_done"}, BUSY, 1'b1);
        check_result(tag, a, b);
      end
    end
    START = 1'b0;
    tick();
    chk({tag, "_done_fall"}, DONE, 1'b0);
    chk({tag, "_busy_fall"}, BUSY, 1'b0);
    chk({tag, "_d_after"},   D,    prev_d);
  endtask

  initial begin
    logic [W-1:0] ca, cb;
    RST = 1'b1; START = 1'b0; A = '0; B = '0;
    tick();
    tick();
    RST = 1'b0;
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_d",    D,    8'h00);
    chk("rst_bout", BOUT, 1'b0);
    chk("rst_zero", ZERO, 1'b1);
    prev_d = 8'h00; prev_bout = 1'b0; prev_zero = 1'b1;

    do_op("op_05_03", 8'h05, 8'h03, 1'b0);
    do_op("op_03_05", 8'h03, 8'h05, 1'b0);
    do_op("op_00_01", 8'h00, 8'h01, 1'b0);
    do_op("op_ff_ff", 8'hFF, 8'hFF, 1'b0);
    do_op("op_80_7f", 8'h80, 8'h7F, 1'b0);
    do_op("op_ignore", 8'h05, 8'h03, 1'b1);
    tick();
    chk("ignore_no_restart", BUSY, 1'b0);

    // Reset aborts an operation in its fourth RUN cycle.
    A = 8'h33; B = 8'h11; START = 1'b1;
    tick();
    START = 1'b0;
    for (int n = 1; n <= 3; n++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_done", DONE, 1'b0);
    chk("abort_d",    D,    8'h00);
    chk("abort_bout", BOUT, 1'b0);
    chk("abort_zero", ZERO, 1'b1);
    for (int n = 0; n < W + 2; n++) begin
      tick();
      chk("abort_no_done", DONE, 1'b0);
    end
    prev_d = 8'h00; prev_bout = 1'b0; prev_zero = 1'b1;
    do_op("op_09_04", 8'h09, 8'h04, 1'b0);

    // Back-to-back regression with START held high.
    A = W'($urandom); B = W'($urandom); START = 1'b1;
    for (int op = 0; op < 1000; op++) begin
      ca = A; cb = B;
      tick();
      chk("b2b_busy", BUSY, 1'b1);
      chk("b2b_done_low", DONE, 1'b0);
      A = W'($urandom);
      B = ($urandom_range(0, 7) == 0) ? A : W'($urandom);
      if (op == 999) START = 1'b0;
      for (int n = 1; n <= W; n++) begin
        tick();
        if (n < W) chk("b2b_spacing", DONE, 1'b0);
        else       check_result("b2b", ca, cb);
      end
    end
    tick();
    chk("b2b_end_busy", BUSY, 1'b0);
    chk("b2b_end_done", DONE, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
